fetch_ctrl: RTL and testbench

Sequences instruction fetch for the single-cycle RISC-V core: it owns the PC and issues one request at a time to the instruction memory. It absorbs variable memory latency and holds returned instructions in a 2-entry buffer with a valid/ready handshake to decode. It also handles branch/jump redirects, including squashing a response already in flight. It replaces the free-running PC+4 counter in the fetch path.

---
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps at most one memory request
// in flight, buffers up to two returned instructions for decode, and handles
// branch/jump redirects, including squashing a response that is still in flight.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  // The buffer is fixed at two entries, so a 2-bit count and 1-bit pointers suffice.
  localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'b00,
    ST_WAIT  = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [31:0] buf_code_q [2];
  logic [31:0] buf_pc_q   [2];

  logic issue_s;
  logic push_s;
  logic pop_s;

  // Handshake qualifiers: issue only when idle, room exists and no redirect;
  // a redirect cancels both the push and the pop of the current cycle.
  always_comb begin
    issue_s = (state_q == ST_ISSUE) && (count_q < FULL_COUNT) && !redirect_valid && !reset;
    push_s  = (state_q == ST_WAIT) && mem_rvalid && !redirect_valid;
    pop_s   = (count_q != 2'd0) && inst_ready && !redirect_valid;
  end

  // Next-state logic for the FSM, PC and buffer pointers.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;

    case (state_q)
      ST_ISSUE: begin
        if (issue_s) state_d = ST_WAIT;
        else         state_d = ST_ISSUE;
      end
      ST_WAIT: begin
        // A response always returns to ISSUE; with a redirect it is simply dropped.
        if (mem_rvalid)          state_d = ST_ISSUE;
        else if (redirect_valid) state_d = ST_DRAIN;
        else                     state_d = ST_WAIT;
      end
      ST_DRAIN: begin
        // Swallow the squashed response before issuing anything new.
        if (mem_rvalid) state_d = ST_ISSUE;
        else            state_d = ST_DRAIN;
      end
      default: state_d = ST_ISSUE;
    endcase

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (issue_s) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end else begin
        req_pc_d = req_pc_q;
      end
      if (push_s) tail_d = ~tail_q;
      else        tail_d = tail_q;
      if (pop_s)  head_d = ~head_q;
      else        head_d = head_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // FSM and control registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ISSUE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0000_0000;
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // Instruction buffer storage, written at the tail on each accepted response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_code_q[0] <= 32'h0000_0000;
      buf_code_q[1] <= 32'h0000_0000;
      buf_pc_q[0]   <= 32'h0000_0000;
      buf_pc_q[1]   <= 32'h0000_0000;
    end else if (push_s) begin
      buf_code_q[tail_q] <= mem_rdata;
      buf_pc_q[tail_q]   <= req_pc_q;
    end
  end

  assign mem_req    = issue_s;
  assign mem_addr   = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_code  = buf_code_q[head_q];
  assign inst_pc    = buf_pc_q[head_q];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a queue-based reference model of the
// fetch stream checks every cycle, directed sequences cover the corner cases,
// and a second instance with a high RESET_PC is checked against a vector table.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        mem2_req;
  logic [31:0] mem2_addr;
  logic        mem2_rvalid;
  logic [31:0] mem2_rdata;
  logic        inst2_valid;
  logic [31:0] inst2_code;
  logic [31:0] inst2_pc;
  logic        redirect2_valid;
  logic [31:0] redirect2_pc;
  logic        inst2_ready;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_code(inst_code), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect2_valid), .redirect_pc(redirect2_pc),
    .mem_req(mem2_req), .mem_addr(mem2_addr),
    .mem_rvalid(mem2_rvalid), .mem_rdata(mem2_rdata),
    .inst_valid(inst2_valid), .inst_code(inst2_code), .inst_pc(inst2_pc),
    .inst_ready(inst2_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: fetch PC, the single outstanding request, and the buffer as a queue.
  typedef struct { logic [31:0] pc; logic [31:0] code; } ent_t;
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  bit          m_out;
  logic [31:0] m_out_pc;
  bit          m_squash;

  // Memory environment for the main instance.
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_a;
  int          lat_min, lat_max;

  // 1-cycle memory for the second instance.
  bit          mem2_pend;
  logic [31:0] mem2_a;

  // Observation logs.
  logic [31:0] addr_log[$];
  logic [31:0] pc_log[$];
  int          since_rst;
  int          first_valid;
  bit          last_req;
  logic [31:0] last_addr;
  bit          last_valid;

  typedef struct { bit req; logic [31:0] addr; bit valid; logic [31:0] pc; } vec_t;
  vec_t tbl[7];
  int   tbl_idx;
  bit   tbl_en;

  function automatic logic [31:0] code_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'bx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit exp_req);
    ent_t e;
    bit   pop;
    pop = (m_buf.size() != 0) && inst_ready;
    if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_buf.delete();
      if (m_out) begin
        if (mem_rvalid) begin m_out = 0; m_squash = 0; end
        else m_squash = 1;
      end
    end else begin
      if (pop) void'(m_buf.pop_front());
      if (m_out && mem_rvalid) begin
        if (!m_squash) begin
          e.pc = m_out_pc; e.code = mem_rdata;
          m_buf.push_back(e);
        end
        m_out = 0; m_squash = 0;
      end
      if (exp_req) begin
        m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive memory responses, check at negedge, advance model and memory.
  task automatic cycle();
    bit exp_req;
    mem_rvalid  = mem_busy && (mem_wait == 0);
    mem_rdata   = mem_rvalid ? code_of(mem_a) : 32'hDEAD_BEEF;
    mem2_rvalid = mem2_pend;
    mem2_rdata  = ~mem2_a;
    @(negedge clock);
    exp_req = !reset && !m_out && (m_buf.size() < 2) && !redirect_valid;
    chk("mem_req", mem_req, exp_req);
    if (exp_req) chk("mem_addr", mem_addr, m_pc);
    chk("inst_valid", inst_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) begin
      chk("inst_pc", inst_pc, m_buf[0].pc);
      chk("inst_code", inst_code, m_buf[0].code);
    end
    if (tbl_en && tbl_idx < 7) begin
      chk("t2_req", mem2_req, tbl[tbl_idx].req);
      if (tbl[tbl_idx].req) chk("t2_addr", mem2_addr, tbl[tbl_idx].addr);
      chk("t2_valid", inst2_valid, tbl[tbl_idx].valid);
      if (tbl[tbl_idx].valid) begin
        chk("t2_pc", inst2_pc, tbl[tbl_idx].pc);
        chk("t2_code", inst2_code, ~tbl[tbl_idx].pc);
      end
      tbl_idx++;
    end
    last_req   = mem_req;
    last_addr  = mem_addr;
    last_valid = inst_valid;
    if (mem_req) addr_log.push_back(mem_addr);
    if (inst_valid && inst_ready && !redirect_valid) pc_log.push_back(inst_pc);
    if (!reset) begin
      if (inst_valid && first_valid < 0) first_valid = since_rst;
      since_rst++;
      model_step(exp_req);
    end
    mem2_pend = mem2_req;
    if (mem2_req) mem2_a = mem2_addr;
    if (mem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    if (mem_req) begin
      mem_busy = 1;
      mem_a    = mem_addr;
      mem_wait = $urandom_range(lat_max, lat_min) - 1;
    end
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset assertion mid-cycle; the memory keeps any response in flight.
  task automatic do_reset(input int n);
    #2 reset = 1'b1;
    m_pc = 32'h0000_0000; m_out = 0; m_squash = 0; m_buf.delete();
    repeat (n) cycle();
    reset = 1'b0;
    addr_log.delete(); pc_log.delete();
    since_rst = 0; first_valid = -1;
    if (!tbl_en) begin tbl_en = 1; tbl_idx = 0; end
  endtask

  task automatic wait_req(input logic [31:0] a, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_req && last_addr == a) begin found = 1; break; end
    end
    chk(nm, found, 1);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_busy = 0; mem_wait = 0; mem_a = 32'h0;
    redirect2_valid = 1'b0; redirect2_pc = 32'h0; inst2_ready = 1'b1;
    mem2_rvalid = 1'b0; mem2_rdata = 32'h0; mem2_pend = 0; mem2_a = 32'h0;
    tbl_en = 0; tbl_idx = 0; lat_min = 1; lat_max = 1;
    tbl[0] = '{1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,         1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8};
    tbl[3] = '{1'b0, 32'h0,         1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
    tbl[5] = '{1'b0, 32'h0,         1'b0, 32'h0};
    tbl[6] = '{1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    @(posedge clock); #1;

    // Straight-line fetch with a 1-cycle memory.
    do_reset(2);
    repeat (8) cycle();
    chk("t1_addr0", q_at(addr_log, 0), 32'h0);
    chk("t1_addr1", q_at(addr_log, 1), 32'h4);
    chk("t1_addr2", q_at(addr_log, 2), 32'h8);
    chk("t1_addr3", q_at(addr_log, 3), 32'hC);
    chk("t1_pc0", q_at(pc_log, 0), 32'h0);
    chk("t1_pc1", q_at(pc_log, 1), 32'h4);
    chk("t1_pc2", q_at(pc_log, 2), 32'h8);
    chk("t1_first_valid", first_valid, 32'd2);

    // Decode stalled: buffer fills to two and requests stop.
    do_reset(1);
    inst_ready = 1'b0;
    repeat (10) cycle();
    chk("t2_req_count", addr_log.size(), 32'd2);
    chk("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (8) cycle();
    chk("t2_pc0", q_at(pc_log, 0), 32'h0);
    chk("t2_pc1", q_at(pc_log, 1), 32'h4);
    chk("t2_pc2", q_at(pc_log, 2), 32'h8);

    // Redirect while a 3-cycle request to 0x8 is in flight.
    lat_min = 3; lat_max = 3;
    do_reset(1);
    wait_req(32'h8, "t3_req8");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    addr_log.delete(); pc_log.delete();
    cycle();
    redirect_valid = 1'b0;
    repeat (12) cycle();
    chk("t3_next_addr", q_at(addr_log, 0), 32'h100);
    chk("t3_next_pc", q_at(pc_log, 0), 32'h100);

    // Redirect coincident with the response, buffer non-empty.
    lat_min = 2; lat_max = 2;
    do_reset(1);
    inst_ready = 1'b0;
    wait_req(32'h4, "t4_req4");
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    cycle();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    pc_log.delete();
    cycle();
    chk("t4_flushed", last_valid, 1'b0);
    chk("t4_req", last_req, 1'b1);
    chk("t4_addr", last_addr, 32'h200);
    repeat (4) cycle();
    chk("t4_first_pc", q_at(pc_log, 0), 32'h200);

    // Reset while waiting on a request to 0x20; its response lands after release.
    lat_min = 3; lat_max = 3;
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
    cycle();
    redirect_valid = 1'b0;
    wait_req(32'h20, "t5_req20");
    cycle();
    do_reset(1);
    cycle();
    chk("t5_req", last_req, 1'b1);
    chk("t5_addr", last_addr, 32'h0);
    chk("t5_valid", last_valid, 1'b0);
    repeat (6) cycle();
    chk("t5_first_pc", q_at(pc_log, 0), 32'h0);

    // Randomized traffic against the reference model.
    lat_min = 1; lat_max = 4;
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      if ($urandom_range(0, 299) == 0) begin
        redirect_valid = 1'b0;
        do_reset(1);
      end else begin
        cycle();
      end
    end
    redirect_valid = 1'b0;
    chk("t2_table_done", tbl_idx, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
